emit_scheduler: RTL

Upstream feeder for the serial output emitter. Accepts parallel words from the datapath through a valid/ready push interface and buffers them in a small FIFO. Presents each word to the emitter on emit_data with emit_ready held high for a programmable window of at least OUTPUT_WIDTH+1 cycles, then forces a low gap so the emitter's bit counter rearms.

---
 rtl/emit_sched_pkg.sv | 14 +
 rtl/emit_scheduler_fifo.sv | 75 +++++++
 rtl/emit_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/emit_sched_pkg.sv
// Shared definitions for the emit scheduler slice: FSM state encoding,
// default word width and the width of the optional words-sent counter.
package emit_sched_pkg;

  localparam int DEFAULT_OUTPUT_WIDTH = 16;
  localparam int STATS_WIDTH          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/emit_scheduler_fifo.sv
// sync_fifo: single-clock word FIFO with occupancy count.
// Push is ignored when full and pop is ignored when empty. data_o always
// shows the head word; the consumer registers it on the pop edge.
module sync_fifo
  import emit_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_OUTPUT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     fast_clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage write; contents need no reset because pointers define validity.
  always_ff @(posedge fast_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Next pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous active-low clear.
  always_ff @(posedge fast_clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/emit_scheduler.sv
// emit_scheduler: buffers datapath words and presents each one to the serial
// emitter with emit_ready held high for HOLD_CYCLES, followed by a low gap of
// GAP_CYCLES so the emitter's bit counter rearms.
// Optional build macro EMIT_SCHED_STATS_EN adds a saturating words_sent port.
module emit_scheduler
  import emit_sched_pkg::*;
#(
  parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH,
  parameter int DEPTH        = 4,
  parameter int HOLD_CYCLES  = OUTPUT_WIDTH + 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                     fast_clk,
  input  logic                     reset,
  input  logic [OUTPUT_WIDTH-1:0]  in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OUTPUT_WIDTH-1:0]  emit_data,
  output logic                     emit_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
`ifdef EMIT_SCHED_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]   words_sent
`endif
);

  // Counters sized to hold their terminal value.
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  sched_state_e            state_q, state_d;
  logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic [OUTPUT_WIDTH-1:0] emit_data_q, emit_data_d;
  logic                    emit_ready_q, emit_ready_d;

  logic [OUTPUT_WIDTH-1:0] fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic [$clog2(DEPTH):0]  fifo_count;

  sync_fifo #(
    .WIDTH (OUTPUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .fast_clk (fast_clk),
    .reset    (reset),
    .push_i   (in_valid),
    .data_i   (in_data),
    .pop_i    (fifo_pop),
    .data_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign in_ready   = !fifo_full;
  assign emit_data  = emit_data_q;
  assign emit_ready = emit_ready_q;
  assign count      = fifo_count;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

  // Next-state logic: pop on entry to HOLD, count hold then gap cycles.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    emit_data_d  = emit_data_q;
    emit_ready_d = emit_ready_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          emit_data_d  = fifo_head;
          emit_ready_d = 1'b1;
          hold_cnt_d   = '0;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          emit_ready_d = 1'b0;
          gap_cnt_d    = '0;
          state_d      = GAP;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (!fifo_empty) begin
            // Back-to-back words skip IDLE so the period stays HOLD+GAP.
            fifo_pop     = 1'b1;
            emit_data_d  = fifo_head;
            emit_ready_d = 1'b1;
            hold_cnt_d   = '0;
            state_d      = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        emit_ready_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge fast_clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      emit_data_q  <= '0;
      emit_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      emit_data_q  <= emit_data_d;
      emit_ready_q <= emit_ready_d;
    end
  end

`ifdef EMIT_SCHED_STATS_EN
  logic [STATS_WIDTH-1:0] words_sent_q;

  assign words_sent = words_sent_q;

  // Count completed hold windows, saturating at all-ones.
  always_ff @(posedge fast_clk) begin
    if (!reset) begin
      words_sent_q <= '0;
    end else if ((state_q == HOLD) && (state_d == GAP) && (words_sent_q != '1)) begin
      words_sent_q <= words_sent_q + 1'b1;
    end
  end
`endif

endmodule
